// File: rtl/half_adder_checker.sv
// rtl/half_adder_checker.sv - response checker for the switch-level half adder
// Optional first-mismatch capture of fail_vec: HA_CHECK_FIRST_FAIL_CAPTURE_EN
module half_adder_checker #(
  parameter int LAT   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             s,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             err_pulse,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] drain_cnt;
  logic       push;
  logic       pv;
  logic       pa;
  logic       pb;
  logic       compare;
  logic       exp_c;
  logic       exp_s;
  logic       mism;
  logic       verdict_ok;

  // Entries arriving alongside a start are dropped: start clears the pipeline.
  assign push = (state == RUN) && in_valid && !start;

  generate
    if (LAT == 0) begin : g_wire
      assign pv = push;
      assign pa = a;
      assign pb = b;
    end else begin : g_pipe
      logic [LAT-1:0] v_q;
      logic [LAT-1:0] a_q;
      logic [LAT-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n || start) begin
          v_q <= '0;
        end else begin
          v_q[0] <= push;
          for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
        end
        a_q[0] <= a;
        b_q[0] <= b;
        for (int i = 1; i < LAT; i++) begin
          a_q[i] <= a_q[i-1];
          b_q[i] <= b_q[i-1];
        end
      end

      assign pv = v_q[LAT-1];
      assign pa = a_q[LAT-1];
      assign pb = b_q[LAT-1];
    end
  endgenerate

  assign compare = pv && ((state == RUN) || (state == DRAIN)) && !start;
  assign exp_c   = pa & pb;
  assign exp_s   = pa ^ pb;

  // Four-state compare in simulation so an X/Z response is a mismatch.
`ifndef SYNTHESIS
  assign mism = compare && ((c !== exp_c) || (s !== exp_s));
`else
  assign mism = compare && ((c != exp_c) || (s != exp_s));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (start)     state_nxt = RUN;
        else if (stop) state_nxt = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (start)                           state_nxt = RUN;
        else if (drain_cnt == 3'(LAT - 1)) state_nxt = DONE;
      end
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      vec_cnt   <= '0;
      err_cnt   <= '0;
      cov       <= 4'b0000;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= mism;
      if (compare) begin
        if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_ONE;
        cov[{pa, pb}] <= 1'b1;
        if (mism && (err_cnt != '1)) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

`ifdef HA_CHECK_FIRST_FAIL_CAPTURE_EN
  logic       captured;
  logic [3:0] fail_vec_q;

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      captured   <= 1'b0;
      fail_vec_q <= 4'b0000;
    end else if (mism && !captured) begin
      captured   <= 1'b1;
      fail_vec_q <= {pa, pb, c, s};
    end
  end

  assign fail_vec = fail_vec_q;
`else
  assign fail_vec = 4'b0000;
`endif

  assign verdict_ok = (err_cnt == '0) && (cov == 4'b1111) && (vec_cnt != '0);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign pass       = (state == DONE) && verdict_ok;
  assign fail       = (state == DONE) && !verdict_ok;

endmodule

// File: tb/tb_half_adder_checker.sv
// tb/tb_half_adder_checker.sv - scoreboard bench for half_adder_checker
// Three instances (LAT/CNT_W = 0/8, 2/8, 1/2) share one stimulus stream.
module tb_half_adder_checker;

  localparam int NI = 3;
  localparam int LATS[NI] = '{0, 2, 1};
  localparam int WS[NI]   = '{8, 8, 2};

  typedef struct {
    int       due;
    bit       mis;
    bit [3:0] abcs;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, stop, in_valid, a, b;
  bit   bad_s = 1'b0;
  bit   mon_en = 1'b0;

  // Stand-in DUT: a half adder delayed by each instance's latency.
  bit [1:0] hist[4];
  always @(posedge clk) begin
    for (int i = 3; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= {a & b, a ^ b};
  end

  logic c0, s0, c1, s1, c2, s2;
  assign c0 = a & b;
  assign s0 = bad_s ? 1'b0 : (a ^ b);
  assign c1 = hist[1][1];
  assign s1 = bad_s ? 1'b0 : hist[1][0];
  assign c2 = hist[0][1];
  assign s2 = bad_s ? 1'b0 : hist[0][0];

  logic       busy0, pass0, fail0, ep0, busy1, pass1, fail1, ep1, busy2, pass2, fail2, ep2;
  logic [7:0] vc0, ec0, vc1, ec1;
  logic [1:0] vc2, ec2;
  logic [3:0] cov0, cov1, cov2, fv0, fv1, fv2;

  half_adder_checker #(.LAT(LATS[0]), .CNT_W(WS[0])) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .c(c0), .s(s0), .busy(busy0), .pass(pass0), .fail(fail0),
    .err_pulse(ep0), .vec_cnt(vc0), .err_cnt(ec0), .cov(cov0), .fail_vec(fv0));

  half_adder_checker #(.LAT(LATS[1]), .CNT_W(WS[1])) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .c(c1), .s(s1), .busy(busy1), .pass(pass1), .fail(fail1),
    .err_pulse(ep1), .vec_cnt(vc1), .err_cnt(ec1), .cov(cov1), .fail_vec(fv1));

  half_adder_checker #(.LAT(LATS[2]), .CNT_W(WS[2])) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .c(c2), .s(s2), .busy(busy2), .pass(pass2), .fail(fail2),
    .err_pulse(ep2), .vec_cnt(vc2), .err_cnt(ec2), .cov(cov2), .fail_vec(fv2));

  ent_t     sbq[NI][$];
  int       m_vec[NI];
  int       m_err[NI];
  bit [3:0] m_cov[NI];
  bit [3:0] m_fv[NI];
  bit       m_cap[NI];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      sbq[k].delete();
      m_vec[k] = 0;
      m_err[k] = 0;
      m_cov[k] = 4'b0000;
      m_fv[k]  = 4'b0000;
      m_cap[k] = 1'b0;
    end
  endtask

  task automatic snap(input int k, output logic bz, output logic ps, output logic fl,
                      output logic ep, output logic [7:0] vc, output logic [7:0] ec,
                      output logic [3:0] cv, output logic [3:0] fv);
    case (k)
      0: begin bz = busy0; ps = pass0; fl = fail0; ep = ep0; vc = vc0; ec = ec0; cv = cov0; fv = fv0; end
      1: begin bz = busy1; ps = pass1; fl = fail1; ep = ep1; vc = vc1; ec = ec1; cv = cov1; fv = fv1; end
      default: begin
        bz = busy2; ps = pass2; fl = fail2; ep = ep2;
        vc = {6'b0, vc2}; ec = {6'b0, ec2}; cv = cov2; fv = fv2;
      end
    endcase
  endtask

  task automatic mon(input int k, input logic ep, input logic [7:0] vc,
                     input logic [7:0] ec, input logic [3:0] cv);
    ent_t e;
    int   maxv;
    maxv = (1 << WS[k]) - 1;
    if (sbq[k].size() != 0 && sbq[k][0].due <= cyc) begin
      e = sbq[k].pop_front();
      if (m_vec[k] < maxv) m_vec[k]++;
      m_cov[k][e.abcs[3:2]] = 1'b1;
      if (e.mis) begin
        if (m_err[k] < maxv) m_err[k]++;
        if (!m_cap[k]) begin
          m_cap[k] = 1'b1;
          m_fv[k]  = e.abcs;
        end
      end
      chk($sformatf("u%0d err_pulse", k), (ep === 1'b1) ? 1 : 0, int'(e.mis));
      chk($sformatf("u%0d vec_cnt", k), int'(vc), m_vec[k]);
      chk($sformatf("u%0d err_cnt", k), int'(ec), m_err[k]);
      chk($sformatf("u%0d cov", k), int'(cv), int'(m_cov[k]));
    end else if (ep !== 1'b0) begin
      chk($sformatf("u%0d unexpected err_pulse", k), 1, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ep0, vc0, ec0, cov0);
      mon(1, ep1, vc1, ec1, cov1);
      mon(2, ep2, {6'b0, vc2}, {6'b0, ec2}, cov2);
    end
  end

  task automatic check_zero(input string nm);
    logic bz, ps, fl, ep;
    logic [7:0] vc, ec;
    logic [3:0] cv, fv;
    for (int k = 0; k < NI; k++) begin
      snap(k, bz, ps, fl, ep, vc, ec, cv, fv);
      chk($sformatf("%s u%0d outputs", nm, k),
          int'({bz, ps, fl, ep, vc, ec, cv, fv} != 32'd0), 0);
    end
  endtask

  task automatic do_start(input bit with_stop);
    logic bz, ps, fl, ep;
    logic [7:0] vc, ec;
    logic [3:0] cv, fv;
    start = 1'b1;
    stop = with_stop;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    stop = 1'b0;
    clear_model();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      snap(k, bz, ps, fl, ep, vc, ec, cv, fv);
      chk($sformatf("start u%0d busy", k), int'(bz), 1);
      chk($sformatf("start u%0d cleared", k), int'({ps, fl, vc, ec, cv, fv} != 0), 0);
    end
  endtask

  task automatic send(input logic va, input logic vb);
    ent_t e;
    a = va;
    b = vb;
    in_valid = 1'b1;
    for (int k = 0; k < NI; k++) begin
      e.due  = cyc + 1 + LATS[k];
      e.mis  = bad_s && (va ^ vb);
      e.abcs = {va, vb, va & vb, bad_s ? 1'b0 : (va ^ vb)};
      sbq[k].push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_stop();
    logic bz, ps, fl, ep;
    logic [7:0] vc, ec;
    logic [3:0] cv, fv;
    bit   exp_pass;
    int   vt;
    stop = 1'b1;
    in_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        vt = 1 + LATS[k];
        snap(k, bz, ps, fl, ep, vc, ec, cv, fv);
        if (j < vt) begin
          chk($sformatf("drain u%0d busy", k), int'(bz), 1);
          chk($sformatf("drain u%0d verdict", k), int'({ps, fl}), 0);
        end else begin
          exp_pass = (m_err[k] == 0) && (m_cov[k] == 4'b1111) && (m_vec[k] != 0);
          chk($sformatf("verdict u%0d busy", k), int'(bz), 0);
          chk($sformatf("verdict u%0d pass", k), int'(ps), int'(exp_pass));
          chk($sformatf("verdict u%0d fail", k), int'(fl), int'(!exp_pass));
          if (j == vt) begin
            chk($sformatf("verdict u%0d vec_cnt", k), int'(vc), m_vec[k]);
            chk($sformatf("verdict u%0d err_cnt", k), int'(ec), m_err[k]);
            chk($sformatf("verdict u%0d cov", k), int'(cv), int'(m_cov[k]));
`ifdef HA_CHECK_FIRST_FAIL_CAPTURE_EN
            chk($sformatf("verdict u%0d fail_vec", k), int'(fv), int'(m_fv[k]));
`else
            chk($sformatf("verdict u%0d fail_vec", k), int'(fv), 0);
`endif
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    in_valid = 1'b0;
    a = 1'b0;
    b = 1'b0;
    clear_model();
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // stop while idle is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check_zero("idle_stop");

    // all four vectors, good DUT
    do_start(1'b0);
    send(0, 0); send(0, 1); send(1, 0); send(1, 1);
    do_stop();

    // coverage hole
    do_start(1'b0);
    send(0, 0); send(0, 1); send(1, 0);
    do_stop();

    // sum stuck at 0
    bad_s = 1'b1;
    do_start(1'b0);
    send(0, 1); send(1, 1);
    do_stop();
    bad_s = 1'b0;

    // start and stop together restarts, then five vectors saturate CNT_W=2
    do_start(1'b0);
    send(1, 1); send(0, 1); send(1, 0);
    do_start(1'b1);
    send(0, 0); send(0, 1); send(1, 0); send(1, 1); send(1, 1);
    do_stop();

    // reset mid-run
    do_start(1'b0);
    send(0, 1); send(1, 1);
    rst_n = 1'b0;
    tick();
    clear_model();
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      bad_s = ($urandom_range(0, 3) == 0);
      do_start(1'b0);
      n = $urandom_range(3, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        else send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      do_stop();
    end
    bad_s = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
